// File: rtl/ram_word_packer_pkg.sv
// ram_word_packer_pkg: shared state encoding, default widths and word geometry helper
package ram_word_packer_pkg;
    localparam int DEF_ADDR_WIDTH = 6;
    localparam int DEF_DATA_WIDTH = 128;
    localparam int DEF_IN_WIDTH   = 8;
    localparam int DEF_WORD_COUNT = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int bytes_per_word(input int data_width, input int in_width);
        return data_width / in_width;
    endfunction
endpackage

// File: rtl/ram_word_packer_if.sv
// ram_word_packer_if: byte-stream handshake plus RAM write port; master is the packer side
interface ram_word_packer_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 128,
    parameter int IN_WIDTH   = 8
);
    logic [IN_WIDTH-1:0]   in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_wdata;

    modport master (
        input  in_data, in_valid,
        output in_ready, ram_addr, ram_we, ram_wdata
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/ram_word_packer_byte_shifter.sv
// ram_byte_shifter: big-endian byte-to-word shift register with a byte counter flagging the last slot
module ram_byte_shifter
    import ram_word_packer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IN_WIDTH   = DEF_IN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  load,
    input  logic [IN_WIDTH-1:0]   din,
    output logic [DATA_WIDTH-1:0] word_nxt,
    output logic                  word_full
);
    localparam int BPW = bytes_per_word(DATA_WIDTH, IN_WIDTH);
    localparam int CW  = BPW > 1 ? $clog2(BPW) : 1;

    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] word;

    assign word_nxt  = {word[DATA_WIDTH-IN_WIDTH-1:0], din};
    assign word_full = cnt == CW'(BPW - 1);

    // shift each accepted byte in at the bottom so the first byte ends up in the top lane
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt  <= '0;
            word <= '0;
        end else if (load) begin
            cnt  <= word_full ? '0 : cnt + CW'(1);
            word <= word_nxt;
        end
    end
endmodule

// File: rtl/ram_word_packer.sv
// ram_word_packer: packs a byte stream into RAM words and writes one frame; optional RAM_WORD_PACKER_CHECKSUM_EN adds an XOR checksum output
module ram_word_packer
    import ram_word_packer_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IN_WIDTH   = DEF_IN_WIDTH,
    parameter int WORD_COUNT = DEF_WORD_COUNT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    ram_word_packer_if.master     bus,
    output logic                  busy,
    output logic                  done
`ifdef RAM_WORD_PACKER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);
    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  go, xfer, last, word_full;
    logic [DATA_WIDTH-1:0] word_nxt;

    assign bus.in_ready = state == FILL;
    assign bus.ram_we   = state == WRITE;
    assign busy         = state == FILL || state == WRITE;
    assign done         = state == DONE;

    ram_byte_shifter #(.DATA_WIDTH(DATA_WIDTH), .IN_WIDTH(IN_WIDTH)) u_shift (
        .clk       (clk),
        .rst       (rst),
        .clr       (go),
        .load      (xfer),
        .din       (bus.in_data),
        .word_nxt  (word_nxt),
        .word_full (word_full)
    );

    // next state: start only counts when idle or finished; a full word forces one WRITE cycle
    always_comb begin
        go        = start && (state == IDLE || state == DONE);
        xfer      = bus.in_valid && state == FILL;
        last      = word_idx == ADDR_WIDTH'(WORD_COUNT - 1);
        state_nxt = go ? FILL : (xfer && word_full) ? WRITE : state == WRITE ? (last ? DONE : FILL) : state;
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // word counter and registered RAM address/data, captured as the last byte of a word arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            word_idx      <= '0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
        end else begin
            if (go)                 word_idx <= '0;
            else if (state == WRITE) word_idx <= word_idx + ADDR_WIDTH'(1);
            if (xfer && word_full) begin
                bus.ram_addr  <= word_idx;
                bus.ram_wdata <= word_nxt;
            end
        end
    end

`ifdef RAM_WORD_PACKER_CHECKSUM_EN
    // running XOR of every word written in this frame
    always_ff @(posedge clk) begin
        if (rst || go)           checksum <= '0;
        else if (state == WRITE) checksum <= checksum ^ bus.ram_wdata;
    end
`endif
endmodule

// File: tb/tb_ram_word_packer.sv
// tb_ram_word_packer: table-driven and sequence checks of ram_word_packer with WORD_COUNT of 1, 2 and 64
module tb_ram_word_packer;
    import ram_word_packer_pkg::*;

    typedef struct {
        logic         start;
        logic         valid;
        logic [7:0]   data;
        logic         ready;
        logic         we;
        logic         busy;
        logic         done;
        logic [5:0]   addr;
        logic [127:0] wdata;
    } vec_t;

    localparam logic [127:0] W0 = 128'h000102030405060708090A0B0C0D0E0F;

    logic clk = 0, rst = 1, start = 0, in_valid = 0;
    logic [7:0] in_data = 0;
    int sel = 0;
    int checks = 0, errors = 0, acc_cnt = 0;

    always #5 clk = ~clk;

    ram_word_packer_if b1(), b2(), b64();
    logic busy1, done1, busy2, done2, busy64, done64;
    logic in_ready, ram_we, busy, done;
    logic [5:0] ram_addr;
    logic [127:0] ram_wdata;

    assign b1.in_data   = in_data;
    assign b2.in_data   = in_data;
    assign b64.in_data  = in_data;
    assign b1.in_valid  = in_valid && sel == 0;
    assign b2.in_valid  = in_valid && sel == 1;
    assign b64.in_valid = in_valid && sel == 2;

`ifdef RAM_WORD_PACKER_CHECKSUM_EN
    logic [127:0] cs1, cs2, cs64;
`endif

    ram_word_packer #(.WORD_COUNT(1)) u1 (
        .clk(clk), .rst(rst), .start(start && sel == 0), .bus(b1), .busy(busy1), .done(done1)
`ifdef RAM_WORD_PACKER_CHECKSUM_EN
        , .checksum(cs1)
`endif
    );
    ram_word_packer #(.WORD_COUNT(2)) u2 (
        .clk(clk), .rst(rst), .start(start && sel == 1), .bus(b2), .busy(busy2), .done(done2)
`ifdef RAM_WORD_PACKER_CHECKSUM_EN
        , .checksum(cs2)
`endif
    );
    ram_word_packer #(.WORD_COUNT(64)) u64 (
        .clk(clk), .rst(rst), .start(start && sel == 2), .bus(b64), .busy(busy64), .done(done64)
`ifdef RAM_WORD_PACKER_CHECKSUM_EN
        , .checksum(cs64)
`endif
    );

    assign in_ready  = sel == 0 ? b1.in_ready  : sel == 1 ? b2.in_ready  : b64.in_ready;
    assign ram_we    = sel == 0 ? b1.ram_we    : sel == 1 ? b2.ram_we    : b64.ram_we;
    assign ram_addr  = sel == 0 ? b1.ram_addr  : sel == 1 ? b2.ram_addr  : b64.ram_addr;
    assign ram_wdata = sel == 0 ? b1.ram_wdata : sel == 1 ? b2.ram_wdata : b64.ram_wdata;
    assign busy      = sel == 0 ? busy1        : sel == 1 ? busy2        : busy64;
    assign done      = sel == 0 ? done1        : sel == 1 ? done2        : done64;

    logic [5:0]   q_addr[$];
    logic [127:0] q_data[$];
    logic [7:0]   sent[$];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // RAM-side scoreboard: log every write and count every accepted byte
    always @(negedge clk) begin
        #1;
        if (ram_we) begin
            q_addr.push_back(ram_addr);
            q_data.push_back(ram_wdata);
            check("ready_low_in_write", 128'(in_ready), 128'(0));
        end
        if (in_valid && in_ready) acc_cnt++;
    end

    function automatic logic [127:0] pack(input int k);
        logic [127:0] w = '0;
        for (int j = 0; j < 16; j++) w[127-8*j -: 8] = sent[16*k+j];
        return w;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        logic acc;
        in_data  = b;
        in_valid = 1;
        do begin
            acc = in_ready;
            @(negedge clk);
            t++;
        end while (!acc && t < 50);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b, expected 1", in_ready);
        end
    endtask

    task automatic send_n(input int n, input int seed, input bit gaps);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            b = 8'(k * 7 + seed);
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 0;
                @(negedge clk);
            end
            send_byte(b);
            sent.push_back(b);
        end
        in_valid = 0;
    endtask

    task automatic do_start();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("done_reached", 128'(done), 128'(1));
    endtask

    vec_t tv[23];

    initial begin
        tv[0]  = '{0, 1, 8'hAA, 0, 0, 0, 0, 6'd0, 128'd0};
        tv[1]  = '{0, 1, 8'h55, 0, 0, 0, 0, 6'd0, 128'd0};
        tv[2]  = '{1, 0, 8'h00, 0, 0, 0, 0, 6'd0, 128'd0};
        for (int i = 0; i < 16; i++) tv[3+i] = '{0, 1, 8'(i), 1, 0, 1, 0, 6'd0, 128'd0};
        tv[19] = '{0, 0, 8'h00, 0, 1, 1, 0, 6'd0, W0};
        tv[20] = '{0, 0, 8'h00, 0, 0, 0, 1, 6'd0, W0};
        tv[21] = '{1, 0, 8'h00, 0, 0, 0, 1, 6'd0, W0};
        tv[22] = '{0, 0, 8'h00, 1, 0, 1, 0, 6'd0, W0};

        rst = 1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("rst_ready", 128'(in_ready), 128'(0));
            check("rst_we", 128'(ram_we), 128'(0));
            check("rst_addr", 128'(ram_addr), 128'(0));
            check("rst_wdata", ram_wdata, 128'(0));
            check("rst_busy", 128'(busy), 128'(0));
            check("rst_done", 128'(done), 128'(0));
        end
        sel = 0;
        rst = 0;
        q_addr.delete();
        q_data.delete();

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            start    = tv[i].start;
            in_valid = tv[i].valid;
            in_data  = tv[i].data;
            check($sformatf("tv%0d_ready", i), 128'(in_ready), 128'(tv[i].ready));
            check($sformatf("tv%0d_we", i), 128'(ram_we), 128'(tv[i].we));
            check($sformatf("tv%0d_busy", i), 128'(busy), 128'(tv[i].busy));
            check($sformatf("tv%0d_done", i), 128'(done), 128'(tv[i].done));
            check($sformatf("tv%0d_addr", i), 128'(ram_addr), 128'(tv[i].addr));
            check($sformatf("tv%0d_wdata", i), ram_wdata, tv[i].wdata);
        end
        start    = 0;
        in_valid = 0;
        @(negedge clk);
        check("wc1_write_count", 128'(q_addr.size()), 128'(1));

        sel = 2;
        @(negedge clk);
        q_addr.delete();
        q_data.delete();
        sent.delete();
        acc_cnt = 0;
        do_start();
        send_n(1024, 3, 1);
        wait_done();
        check("full_write_count", 128'(q_addr.size()), 128'(64));
        check("full_byte_count", 128'(acc_cnt), 128'(1024));
        check("full_busy_after", 128'(busy), 128'(0));
        if (q_addr.size() == 64)
            for (int k = 0; k < 64; k++) begin
                check($sformatf("full_addr%0d", k), 128'(q_addr[k]), 128'(k));
                check($sformatf("full_data%0d", k), q_data[k], pack(k));
            end

        q_addr.delete();
        q_data.delete();
        sent.delete();
        do_start();
        check("restart_done_cleared", 128'(done), 128'(0));
        check("restart_busy", 128'(busy), 128'(1));
        send_n(16, 11, 0);
        do_start();
        send_n(20, 50, 0);
        check("mid_write_count", 128'(q_addr.size()), 128'(2));
        if (q_addr.size() == 2) begin
            check("mid_addr0", 128'(q_addr[0]), 128'(0));
            check("mid_addr1", 128'(q_addr[1]), 128'(1));
            check("mid_data1", q_data[1], pack(1));
        end
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("abort_no_write", 128'(q_addr.size()), 128'(2));
        check("abort_busy", 128'(busy), 128'(0));
        q_addr.delete();
        q_data.delete();
        sent.delete();
        do_start();
        send_n(16, 99, 0);
        repeat (2) @(negedge clk);
        check("fresh_write_count", 128'(q_addr.size()), 128'(1));
        if (q_addr.size() == 1) begin
            check("fresh_addr", 128'(q_addr[0]), 128'(0));
            check("fresh_data", q_data[0], pack(0));
        end

        sel = 1;
        @(negedge clk);
        q_addr.delete();
        q_data.delete();
        sent.delete();
        do_start();
        send_n(32, 5, 1);
        wait_done();
        check("wc2_write_count", 128'(q_addr.size()), 128'(2));
        if (q_data.size() == 2) begin
            check("wc2_data0", q_data[0], pack(0));
            check("wc2_data1", q_data[1], pack(1));
        end
`ifdef RAM_WORD_PACKER_CHECKSUM_EN
        check("checksum_done", cs2, pack(0) ^ pack(1));
`endif
        do_start();
        check("wc2_restart_done", 128'(done), 128'(0));
        check("wc2_restart_busy", 128'(busy), 128'(1));
`ifdef RAM_WORD_PACKER_CHECKSUM_EN
        check("checksum_cleared", cs2, 128'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1);
    end
endmodule
